// File: rtl/cpu_timer.sv
// Memory-mapped multi-channel timer/counter for the qwic51 decoder bus.
// Each channel: prescaler, reload, one-shot/auto-reload, sticky OVF, level IRQ.
module cpu_timer #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    CHANNELS   = 2,
  parameter int                    CNT_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 8'hC0
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] MEM_WR_DATA,
  input  logic [ADDR_WIDTH-1:0] MEM_ADDR,
  input  logic                  MEM_WR,
  input  logic                  MEM_RD,
  output logic [DATA_WIDTH-1:0] MEM_RD_DATA,
  output logic [CHANNELS-1:0]   IRQ
);

  localparam int              HW   = CNT_WIDTH - DATA_WIDTH;
  localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(8 * CHANNELS);

  logic [ADDR_WIDTH-1:0]               w_off;
  logic [ADDR_WIDTH-4:0]               w_ch;
  logic [2:0]                          w_reg;
  logic                                w_in_range;
  logic [CHANNELS-1:0]                 w_hit;
  logic [CHANNELS-1:0][DATA_WIDTH-1:0] w_rd_vec;
  logic [DATA_WIDTH-1:0]               w_rd_any;
  logic [DATA_WIDTH-1:0]               r_rd_data;

  assign w_off      = MEM_ADDR - BASE_ADDR;
  assign w_ch       = w_off[ADDR_WIDTH-1:3];
  assign w_reg      = w_off[2:0];
  assign w_in_range = (MEM_ADDR >= BASE_ADDR) && ({1'b0, w_off} < SPAN);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic                  r_run, r_mode, r_ie, r_ovf;
    logic [DATA_WIDTH-1:0] r_pre, r_pc;
    logic [CNT_WIDTH-1:0]  r_rld, r_cnt;
    logic [HW-1:0]         r_shadow;
    logic                  w_wr, w_rd, w_tick, w_cnt_wr, w_ovf_evt;
    logic [DATA_WIDTH-1:0] w_rd_val;

    assign w_hit[c]  = w_in_range && (w_ch == (ADDR_WIDTH-3)'(c));
    assign w_wr      = MEM_WR && w_hit[c];
    assign w_rd      = MEM_RD && w_hit[c];
    assign w_tick    = r_run && (r_pc == r_pre);
    // A direct count load swallows a coincident tick, including its overflow.
    assign w_cnt_wr  = w_wr && ((w_reg == 3'd4) || (w_reg == 3'd5));
    assign w_ovf_evt = w_tick && !w_cnt_wr && (r_cnt == {CNT_WIDTH{1'b1}});
    assign IRQ[c]    = r_ovf & r_ie;

    always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
        r_pc <= '0;
      end else if ((w_wr && (w_reg == 3'd1)) || !r_run || w_tick) begin
        r_pc <= '0;
      end else begin
        r_pc <= r_pc + DATA_WIDTH'(1);
      end
    end

    always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
        r_run  <= 1'b0;
        r_mode <= 1'b0;
        r_ie   <= 1'b0;
        r_ovf  <= 1'b0;
      end else begin
        if (w_wr && (w_reg == 3'd0)) begin
          r_run  <= MEM_WR_DATA[0];
          r_mode <= MEM_WR_DATA[1];
          r_ie   <= MEM_WR_DATA[2];
        end else if (w_ovf_evt && !r_mode) begin
          r_run <= 1'b0;
        end
        // Overflow set takes priority over a same-cycle W1C.
        if (w_ovf_evt) begin
          r_ovf <= 1'b1;
        end else if (w_wr && (w_reg == 3'd0) && MEM_WR_DATA[7]) begin
          r_ovf <= 1'b0;
        end
      end
    end

    always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
        r_pre    <= '0;
        r_rld    <= '0;
        r_cnt    <= '0;
        r_shadow <= '0;
      end else begin
        if (w_wr && (w_reg == 3'd1)) r_pre <= MEM_WR_DATA;
        if (w_wr && (w_reg == 3'd2)) r_rld[DATA_WIDTH-1:0] <= MEM_WR_DATA;
        if (w_wr && (w_reg == 3'd3)) r_rld[CNT_WIDTH-1:DATA_WIDTH] <= MEM_WR_DATA[HW-1:0];
        if (w_wr && (w_reg == 3'd4)) begin
          r_cnt[DATA_WIDTH-1:0] <= MEM_WR_DATA;
        end else if (w_wr && (w_reg == 3'd5)) begin
          r_cnt[CNT_WIDTH-1:DATA_WIDTH] <= MEM_WR_DATA[HW-1:0];
        end else if (w_ovf_evt) begin
          r_cnt <= r_rld;
        end else if (w_tick) begin
          r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
        if (w_rd && (w_reg == 3'd4)) r_shadow <= r_cnt[CNT_WIDTH-1:DATA_WIDTH];
      end
    end

    always_comb begin
      w_rd_val = '0;
      if (w_hit[c]) begin
        case (w_reg)
          3'd0: begin
            w_rd_val[0] = r_run;
            w_rd_val[1] = r_mode;
            w_rd_val[2] = r_ie;
            w_rd_val[7] = r_ovf;
          end
          3'd1:    w_rd_val = r_pre;
          3'd2:    w_rd_val = r_rld[DATA_WIDTH-1:0];
          3'd3:    w_rd_val = DATA_WIDTH'(r_rld[CNT_WIDTH-1:DATA_WIDTH]);
          3'd4:    w_rd_val = r_cnt[DATA_WIDTH-1:0];
          3'd5:    w_rd_val = DATA_WIDTH'(r_shadow);
          default: w_rd_val = '0;
        endcase
      end else begin
        w_rd_val = '0;
      end
    end

    assign w_rd_vec[c] = w_rd_val;
  end

  always_comb begin
    w_rd_any = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_rd_any = w_rd_any | w_rd_vec[i];
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_rd_data <= '0;
    end else if (MEM_RD) begin
      r_rd_data <= w_rd_any;
    end else begin
      r_rd_data <= '0;
    end
  end

  assign MEM_RD_DATA = r_rd_data;

endmodule

// File: tb/tb_cpu_timer.sv
// Scoreboard bench for cpu_timer: reads push expectations, a monitor checks returned data.
module tb_cpu_timer;
  logic       CLK;
  logic       RESET;
  logic [7:0] MEM_WR_DATA;
  logic [7:0] MEM_ADDR;
  logic       MEM_WR;
  logic       MEM_RD;
  logic [7:0] MEM_RD_DATA;
  logic [1:0] IRQ;

  int checks;
  int errors;
  logic [7:0] q_exp[$];
  string      q_name[$];
  logic       rd_seen;

  cpu_timer dut (
    .CLK(CLK), .RESET(RESET), .MEM_WR_DATA(MEM_WR_DATA), .MEM_ADDR(MEM_ADDR),
    .MEM_WR(MEM_WR), .MEM_RD(MEM_RD), .MEM_RD_DATA(MEM_RD_DATA), .IRQ(IRQ)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) rd_seen <= 1'b0;
    else        rd_seen <= MEM_RD;
  end

  // Monitor: read data must match the queued expectation, otherwise the bus must be 0.
  always @(negedge CLK) begin
    logic [7:0] exp_v;
    string      nm;
    if (rd_seen) begin
      checks++;
      if (q_exp.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: got %02h, no expectation queued", MEM_RD_DATA);
      end else begin
        exp_v = q_exp.pop_front();
        nm    = q_name.pop_front();
        if (MEM_RD_DATA !== exp_v) begin
          errors++;
          $display("FAIL %s: got %02h, expected %02h", nm, MEM_RD_DATA, exp_v);
        end
      end
    end else begin
      checks++;
      if (MEM_RD_DATA !== 8'h00) begin
        errors++;
        $display("FAIL idle_rd_data: got %02h, expected 00", MEM_RD_DATA);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    MEM_ADDR = a; MEM_WR_DATA = d; MEM_WR = 1'b1;
    step();
    MEM_WR = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] e, input string nm);
    MEM_ADDR = a; MEM_RD = 1'b1;
    q_exp.push_back(e);
    q_name.push_back(nm);
    step();
    MEM_RD = 1'b0;
  endtask

  task automatic rdwr(input logic [7:0] a, input logic [7:0] d, input logic [7:0] e, input string nm);
    MEM_ADDR = a; MEM_WR_DATA = d; MEM_WR = 1'b1; MEM_RD = 1'b1;
    q_exp.push_back(e);
    q_name.push_back(nm);
    step();
    MEM_WR = 1'b0; MEM_RD = 1'b0;
  endtask

  task automatic chk_irq(input logic [1:0] e, input string nm);
    checks++;
    if (IRQ !== e) begin
      errors++;
      $display("FAIL %s: IRQ got %b, expected %b", nm, IRQ, e);
    end
  endtask

  initial begin
    logic [7:0] a;
    checks = 0; errors = 0;
    RESET = 1'b0; MEM_WR_DATA = 8'h00; MEM_ADDR = 8'h00; MEM_WR = 1'b0; MEM_RD = 1'b0;
    steps(3);
    RESET = 1'b1;
    chk_irq(2'b00, "reset_irq");
    for (int i = 0; i < 16; i++) begin
      a = 8'hC0 + 8'(i);
      rd(a, 8'h00, $sformatf("reset_reg_%02h", a));
    end

    // Auto-reload: RLD=FFF0, count=FFF0, RUN write at edge k
    wr(8'hC2, 8'hF0); wr(8'hC3, 8'hFF); wr(8'hC4, 8'hF0); wr(8'hC5, 8'hFF);
    wr(8'hC0, 8'h07);
    steps(15);
    chk_irq(2'b00, "ar_before_ovf");
    step();
    chk_irq(2'b01, "ar_ovf_irq");
    rd(8'hC4, 8'hF0, "ar_reload_cnt_l");
    rd(8'hC5, 8'hFF, "ar_reload_cnt_h");
    rd(8'hC0, 8'h87, "ar_ctrl");
    wr(8'hC0, 8'h87);
    chk_irq(2'b00, "ar_w1c_irq");
    steps(11);
    chk_irq(2'b00, "ar_period_before");
    step();
    chk_irq(2'b01, "ar_period_ovf");
    rd(8'hC4, 8'hF0, "ar_second_reload");
    wr(8'hC0, 8'h80);
    chk_irq(2'b00, "ar_stop_irq");

    // Prescaler: PRE=3, RUN for 40 clocks -> 10 ticks
    wr(8'hC9, 8'h03);
    wr(8'hC8, 8'h01);
    steps(39);
    wr(8'hC8, 8'h00);
    rd(8'hCC, 8'h0A, "pre_count_l");
    rd(8'hCD, 8'h00, "pre_count_h");
    wr(8'hCC, 8'h00);
    wr(8'hC8, 8'h01);
    step();
    wr(8'hC9, 8'h03);
    steps(2);
    rd(8'hCC, 8'h00, "pre_restart_no_tick");
    step();
    rd(8'hCC, 8'h01, "pre_restart_tick");
    wr(8'hC8, 8'h00);

    // One-shot: RLD=count=FFFE, IE set
    wr(8'hC2, 8'hFE); wr(8'hC3, 8'hFF); wr(8'hC4, 8'hFE); wr(8'hC5, 8'hFF);
    wr(8'hC0, 8'h85);
    step();
    chk_irq(2'b00, "os_before_ovf");
    step();
    chk_irq(2'b01, "os_ovf_irq");
    rd(8'hC0, 8'h84, "os_ctrl");
    rd(8'hC4, 8'hFE, "os_cnt_l");
    rd(8'hC5, 8'hFF, "os_cnt_h");
    steps(3);
    rd(8'hC4, 8'hFE, "os_cnt_held");

    // Collision: W1C on the overflow edge, then CTRL write on an overflow edge
    wr(8'hC4, 8'hFE); wr(8'hC5, 8'hFF);
    wr(8'hC0, 8'h87);
    step();
    wr(8'hC0, 8'h87);
    rd(8'hC0, 8'h87, "col_w1c_vs_ovf");
    chk_irq(2'b01, "col_w1c_irq");
    wr(8'hC0, 8'h80);
    rd(8'hC0, 8'h80, "col_stop_on_ovf");
    wr(8'hC0, 8'h80);
    rd(8'hC0, 8'h00, "col_ovf_cleared");

    // Atomic read: count 00FF at PRE=0
    wr(8'hC9, 8'h00); wr(8'hCC, 8'hFF); wr(8'hCD, 8'h00);
    wr(8'hC8, 8'h01);
    rd(8'hCC, 8'hFF, "atom_cnt_l");
    steps(4);
    rd(8'hCD, 8'h00, "atom_shadow_h");
    rd(8'hCC, 8'h05, "atom_cnt_l2");
    rd(8'hCD, 8'h01, "atom_shadow_h2");
    wr(8'hC8, 8'h00);

    // Collision: CNT_L write on a tick edge
    wr(8'hCD, 8'h00);
    wr(8'hC8, 8'h01);
    wr(8'hCC, 8'h55);
    rd(8'hCC, 8'h55, "col_cnt_write_wins");
    rd(8'hCC, 8'h56, "col_cnt_next_tick");
    wr(8'hC8, 8'h00);

    // Simultaneous read/write, unmapped addresses
    rdwr(8'hC9, 8'h07, 8'h00, "rdwr_pre_value");
    rd(8'hC9, 8'h07, "rdwr_post_value");
    wr(8'hD0, 8'hFF);
    rd(8'hD0, 8'h00, "unmapped_d0");
    rd(8'hBF, 8'h00, "unmapped_bf");

    // Reset in the middle of counting
    wr(8'hC9, 8'h00);
    wr(8'hC8, 8'h01);
    steps(3);
    RESET = 1'b0;
    steps(2);
    RESET = 1'b1;
    rd(8'hCC, 8'h00, "midrst_cnt_l");
    rd(8'hCD, 8'h00, "midrst_cnt_h");
    rd(8'hC8, 8'h00, "midrst_ctrl");
    rd(8'hC9, 8'h00, "midrst_pre");
    chk_irq(2'b00, "midrst_irq");
    steps(3);

    checks++;
    if (q_exp.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q_exp.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
